adc_snapshot_capture: RTL and testbench

Downstream consumer of the ADC signed-conversion stage.
- Takes one core's signed parallel-sample bus and arms on command.
- Captures 2^ADDR_WIDTH consecutive bus words into an internal RAM, starting on an external or threshold trigger.
- Then streams the snapshot out over a valid/ready interface to the debug/readout logic.
- Instantiated once per core (A–D) in the PSR/RSR datapath.

---
 rtl/adc_snapshot_capture.sv | 147 ++++++++++++++
 tb/tb_adc_snapshot_capture.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_snapshot_capture.sv
// Snapshot capture for one ADC core: arm, wait for an external or threshold
// trigger, record 2^ADDR_WIDTH consecutive sample words, then stream them out
// over a valid/ready port.
module adc_snapshot_capture #(
  parameter int unsigned ADC_DATA_WIDTH = 8,
  parameter int unsigned PATH_NUM       = 4,
  parameter int unsigned ADDR_WIDTH     = 10
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [ADC_DATA_WIDTH*PATH_NUM-1:0] adc_signed_all_bit_i,
  input  logic                               arm_i,
  input  logic                               trig_mode_i,
  input  logic                               trig_i,
  input  logic [ADC_DATA_WIDTH-1:0]          thresh_i,
  output logic                               busy_o,
  output logic                               done_o,
  output logic [ADC_DATA_WIDTH*PATH_NUM-1:0] rd_data_o,
  output logic                               rd_valid_o,
  input  logic                               rd_ready_i,
  output logic                               rd_last_o
);

  localparam int unsigned DW    = ADC_DATA_WIDTH * PATH_NUM;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READ} state_t;

  state_t                state, state_next;
  logic                  thresh_hit, trig_hit, we, issue, pop;
  logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;
  logic                  rd_issue_done;
  logic [DW-1:0]         mem [DEPTH];
  logic [DW-1:0]         ram_q;
  logic                  ram_last, inflight;
  logic [DW-1:0]         skid_data [2];
  logic [1:0]            skid_last;
  logic                  skid_wr, skid_rd;
  logic [1:0]            skid_cnt, occ;

  // Trigger condition on the current input word
  always_comb begin
    thresh_hit = 1'b0;
    for (int unsigned k = 0; k < PATH_NUM; k++) begin
      if ($signed(adc_signed_all_bit_i[k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]) > $signed(thresh_i))
        thresh_hit = 1'b1;
    end
    trig_hit = trig_mode_i ? thresh_hit : trig_i;
  end

  assign rd_valid_o = (skid_cnt != 2'd0);
  assign rd_data_o  = skid_data[skid_rd];
  assign rd_last_o  = rd_valid_o & skid_last[skid_rd];
  assign pop        = rd_valid_o & rd_ready_i;

  // Words that will sit in the skid after this edge; a new RAM read is only
  // issued when its result is guaranteed a free skid slot on arrival.
  assign occ   = skid_cnt + {1'b0, inflight} - {1'b0, pop};
  assign issue = (state == READ) && !rd_issue_done && (occ <= 2'd1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and RAM write enable
  always_comb begin
    state_next = state;
    we         = 1'b0;
    case (state)
      IDLE:    if (arm_i) state_next = ARMED;
      ARMED:   if (trig_hit) begin
                 we         = 1'b1;
                 state_next = CAPTURE;
               end
      CAPTURE: begin
                 we = 1'b1;
                 if (wr_addr == '1) state_next = READ;
               end
      READ:    if (pop && rd_last_o) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Write address, busy and sticky done flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      wr_addr <= (we && state_next == CAPTURE) ? wr_addr + 1'b1 : '0;
      busy_o  <= (state_next != IDLE);
      if (state == IDLE && arm_i)
        done_o <= 1'b0;
      else if (state == READ && pop && rd_last_o)
        done_o <= 1'b1;
    end
  end

  // Snapshot RAM: write port for capture, registered read port for readout
  always_ff @(posedge clk) begin
    if (we)    mem[wr_addr] <= adc_signed_all_bit_i;
    if (issue) ram_q        <= mem[rd_addr];
  end

  // Read issue and 2-entry skid that hides the RAM read latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_addr       <= '0;
      rd_issue_done <= 1'b0;
      inflight      <= 1'b0;
      ram_last      <= 1'b0;
      skid_wr       <= 1'b0;
      skid_rd       <= 1'b0;
      skid_cnt      <= '0;
      skid_last     <= '0;
      skid_data[0]  <= '0;
      skid_data[1]  <= '0;
    end else if (state != READ) begin
      rd_addr       <= '0;
      rd_issue_done <= 1'b0;
      inflight      <= 1'b0;
      ram_last      <= 1'b0;
      skid_wr       <= 1'b0;
      skid_rd       <= 1'b0;
      skid_cnt      <= '0;
      skid_last     <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        ram_last <= (rd_addr == '1);
        if (rd_addr == '1) rd_issue_done <= 1'b1;
        else               rd_addr       <= rd_addr + 1'b1;
      end
      if (inflight) begin
        skid_data[skid_wr] <= ram_q;
        skid_last[skid_wr] <= ram_last;
        skid_wr            <= ~skid_wr;
      end
      if (pop) skid_rd <= ~skid_rd;
      skid_cnt <= skid_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_adc_snapshot_capture.sv
// Scoreboard bench for adc_snapshot_capture (16-word snapshots, 4 x 8-bit samples).
module tb_adc_snapshot_capture;

  localparam int unsigned W     = 8;
  localparam int unsigned PN    = 4;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = W * PN;
  localparam int unsigned DEPTH = 1 << AW;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] adc_word;
  logic          arm_i, trig_mode_i, trig_i, rd_ready_i;
  logic [W-1:0]  thresh_i;
  logic          busy_o, done_o, rd_valid_o, rd_last_o;
  logic [DW-1:0] rd_data_o;

  int            nchk = 0;
  int            nfail = 0;

  // Bench-side model state
  exp_t          sbq[$];
  logic [DW-1:0] col[$];
  int            phase = 0;       // 0 idle, 1 armed, 2 collecting, 3 draining
  bit            exp_done = 1'b0;
  int            drain_cyc = 0;
  bit            rst_hit = 1'b0;
  bit            mon_en = 1'b0;

  // Input word source
  int            data_mode = 1;   // 0 ramp, 1 random, 2 held
  logic [DW-1:0] held_word = '0;
  int unsigned   cyc = 0;

  adc_snapshot_capture #(
    .ADC_DATA_WIDTH(W),
    .PATH_NUM      (PN),
    .ADDR_WIDTH    (AW)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .adc_signed_all_bit_i(adc_word),
    .arm_i               (arm_i),
    .trig_mode_i         (trig_mode_i),
    .trig_i              (trig_i),
    .thresh_i            (thresh_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .rd_data_o           (rd_data_o),
    .rd_valid_o          (rd_valid_o),
    .rd_ready_i          (rd_ready_i),
    .rd_last_o           (rd_last_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit fires(input logic [DW-1:0] w, input logic mode,
                               input logic t, input logic [W-1:0] th);
    bit hit = 1'b0;
    for (int i = 0; i < int'(PN); i++)
      if ($signed(w[i*W +: W]) > $signed(th)) hit = 1'b1;
    return mode ? hit : t;
  endfunction

  // Input word driver, updated shortly after each rising edge
  always begin
    @(posedge clk);
    #2;
    cyc++;
    case (data_mode)
      0:       adc_word = DW'(cyc);
      1:       adc_word = DW'($urandom);
      default: adc_word = held_word;
    endcase
  end

  // Reference model: snapshot = the 16 input words starting at the first
  // triggering cycle after an arm; readout finishes when all are accepted.
  always @(posedge clk) begin
    exp_t e;
    if (!rst_n) begin
      phase = 0; exp_done = 1'b0; drain_cyc = 0; rst_hit = 1'b1;
      sbq.delete(); col.delete();
    end else begin
      case (phase)
        0: if (arm_i) begin phase = 1; exp_done = 1'b0; end
        1: if (fires(adc_word, trig_mode_i, trig_i, thresh_i)) begin
             col.delete(); col.push_back(adc_word); phase = 2;
           end
        2: begin
             col.push_back(adc_word);
             if (col.size() == int'(DEPTH)) begin
               for (int i = 0; i < int'(DEPTH); i++) begin
                 e.data = col[i];
                 e.last = (i == int'(DEPTH) - 1);
                 sbq.push_back(e);
               end
               phase = 3; drain_cyc = 0;
             end
           end
        default: begin
             drain_cyc++;
             if (sbq.size() == 0) begin phase = 0; exp_done = 1'b1; end
           end
      endcase
    end
  end

  // Monitor: status flags, stall stability, and scoreboard pops
  bit            have_prev = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (rst_hit) begin have_prev = 1'b0; rst_hit = 1'b0; end
      chk("busy", busy_o, phase != 0);
      chk("done", done_o, exp_done);
      if (phase == 3 && drain_cyc == 2)
        chk("read_latency", rd_valid_o || sbq.size() < int'(DEPTH), 1);
      if (have_prev && prev_valid && !prev_ready) begin
        chk("stall_valid", rd_valid_o, 1);
        if (rd_valid_o) begin
          chk("stall_data", rd_data_o, prev_data);
          chk("stall_last", rd_last_o, prev_last);
        end
      end
      if (rd_valid_o && rd_ready_i && rst_n) begin
        if (sbq.size() == 0) begin
          chk("extra_word", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("rd_data", rd_data_o, e.data);
          chk("rd_last", rd_last_o, e.last);
        end
      end
      have_prev  = 1'b1;
      prev_valid = rd_valid_o;
      prev_ready = rd_ready_i;
      prev_data  = rd_data_o;
      prev_last  = rd_last_o;
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_arm();
    arm_i = 1'b1; step(1); arm_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done_o) break;
    end
    chk("done_wait", done_o, 1);
    chk("sb_empty", sbq.size(), 0);
    step(1);
  endtask

  task automatic drain_random(input int pct, input int budget);
    for (int k = 0; k < budget && !done_o; k++) begin
      rd_ready_i = ($urandom_range(0, 99) < pct);
      step(1);
    end
    rd_ready_i = 1'b1;
    wait_done(60);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; arm_i = 1'b0; trig_i = 1'b0; trig_mode_i = 1'b0;
    thresh_i = '0; rd_ready_i = 1'b0; adc_word = '0;

    // Reset and idle behaviour
    step(2);
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_valid", rd_valid_o, 0);
    chk("rst_last", rd_last_o, 0);
    chk("rst_data", rd_data_o, 0);
    step(1);
    rst_n = 1'b1;
    repeat (5) begin trig_i = 1'b1; step(1); trig_i = 1'b0; step(1); end
    chk("idle_busy", busy_o, 0);
    chk("idle_valid", rd_valid_o, 0);

    // External trigger on a ramp, full-throughput readout
    data_mode = 0; rd_ready_i = 1'b1;
    pulse_arm();
    step(4);
    trig_i = 1'b1; step(1); trig_i = 1'b0;
    for (k = 0; k < 40; k++) begin @(negedge clk); if (rd_valid_o) break; end
    chk("first_valid", rd_valid_o, 1);
    for (k = 0; k < 40; k++) begin @(negedge clk); if (done_o) break; end
    chk("throughput_cycles", k + 1, DEPTH);
    chk("ext_busy_end", busy_o, 0);
    wait_done(10);

    // Threshold: equal never fires, first strictly greater sample does
    data_mode = 2; trig_mode_i = 1'b1; thresh_i = 8'sd100;
    held_word = {4{8'sd100}};
    pulse_arm();
    step(10);
    chk("thr_equal_busy", busy_o, 1);
    held_word = {8'sd100, 8'sd101, 8'sd100, 8'sd100};
    step(1);
    held_word = {4{8'sd100}};
    wait_done(60);

    // Negative threshold that never fires, then external trigger under backpressure
    thresh_i = -8'sd5;
    held_word = {4{-8'sd6}};
    pulse_arm();
    step(40);
    chk("neg_no_fire_valid", rd_valid_o, 0);
    chk("neg_no_fire_busy", busy_o, 1);
    trig_mode_i = 1'b0; data_mode = 1;
    trig_i = 1'b1; step(1); trig_i = 1'b0;
    drain_random(30, 400);

    // Same-cycle arm+trigger, arms ignored during capture and readout
    rd_ready_i = 1'b0;
    arm_i = 1'b1; trig_i = 1'b1; step(1); arm_i = 1'b0; trig_i = 1'b0;
    step(5);
    chk("arm_trig_busy", busy_o, 1);
    chk("arm_trig_valid", rd_valid_o, 0);
    trig_i = 1'b1; step(1); trig_i = 1'b0;
    step(4);
    pulse_arm();
    for (k = 0; k < 40; k++) begin @(negedge clk); if (rd_valid_o) break; end
    chk("read_start", rd_valid_o, 1);
    step(1);
    pulse_arm();
    step(3);
    rd_ready_i = 1'b1;
    wait_done(60);
    pulse_arm();
    chk("rearm_done_clear", done_o, 0);

    // Reset during capture, then a fresh complete snapshot
    trig_i = 1'b1; step(1); trig_i = 1'b0;
    step(6);
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_valid", rd_valid_o, 0);
    step(3);
    chk("mid_rst_stays_idle", busy_o, 0);
    pulse_arm();
    step(2);
    trig_i = 1'b1; step(1); trig_i = 1'b0;
    drain_random(50, 300);

    // Random thresholds on random data
    trig_mode_i = 1'b1;
    for (int r = 0; r < 3; r++) begin
      thresh_i = W'($urandom_range(60, 120));
      pulse_arm();
      drain_random(60, 600);
    end

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end

endmodule
